// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- request/response bundle for the muldiv_seq unit.
//
// Signals:
//   req_valid/req_ready   request handshake (ready only while the unit is idle)
//   req_op                RV32M funct3 selecting the operation
//   req_rs1/req_rs2       32-bit operands (rs1 = dividend / multiplicand)
//   req_rd                5-bit destination tag echoed on resp_rd
//   kill                  synchronous abort of any in-flight operation
//   resp_valid/resp_ready response handshake
//   resp_data/resp_rd     32-bit result and its tag
//   busy                  unit is not idle
//
// The master modport is the requester/consumer side; the slave modport is the unit.
interface muldiv_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, kill, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, busy
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, kill, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential RV32M multiply/divide unit.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   muldiv_seq_if.slave (request, response, kill, busy)
//
// Divide is radix-2 restoring on operand magnitudes, one bit per cycle for
// 32 cycles. Multiply is shift-add over 32 cycles by default. Divide-by-zero
// and signed overflow resolve on the accept edge without iterating.
//
// Build option: define MULDIV_FAST_MUL_EN to resolve all multiply ops on the
// accept edge with a single-cycle signed 33x33 product.
module muldiv_seq (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opb_q, opb_d;    // multiplicand or divisor magnitude
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        neg_q, neg_d;    // final result must be negated
  logic [31:0] data_q, data_d;

  // ---------------- request decode ----------------
  logic        a_neg, b_neg, req_neg, div_by_zero, div_ovf;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
    a_neg = bus.req_rs1[31] && (bus.req_op inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_neg = bus.req_rs2[31] && (bus.req_op inside {3'b001, 3'b100, 3'b110});
    mag_a = a_neg ? -bus.req_rs1 : bus.req_rs1;
    mag_b = b_neg ? -bus.req_rs2 : bus.req_rs2;
    // Remainder follows the dividend's sign; everything else the sign product.
    req_neg     = (bus.req_op[2] && bus.req_op[1]) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = (bus.req_rs2 == 32'd0);
    div_ovf     = !bus.req_op[0] && (bus.req_rs1 == 32'h8000_0000) &&
                  (bus.req_rs2 == 32'hFFFF_FFFF);
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending both operands to 64 bits and keeping the low 64 product
  // bits gives exactly the 33x33 signed product over the range we use.
  logic [63:0] fast_a, fast_b, fast_p;
  logic [31:0] fast_res;

  always_comb begin
    fast_a   = {{32{a_neg}}, bus.req_rs1};
    fast_b   = {{32{b_neg}}, bus.req_rs2};
    fast_p   = fast_a * fast_b;
    fast_res = (bus.req_op[1:0] == 2'b00) ? fast_p[31:0] : fast_p[63:32];
  end
`endif

  // ---------------- one iteration step ----------------
  logic [32:0] mul_sum, div_tmp;
  logic        div_ge;
  logic [63:0] step, prod;
  logic [31:0] div_sel, fin;

  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Shifted partial remainder is up to 33 bits wide; compare before subtracting.
    div_tmp = acc_q[63:31];
    div_ge  = (div_tmp >= {1'b0, opb_q});
    if (op_q[2]) begin
      step = {(div_ge ? div_tmp[31:0] - opb_q : div_tmp[31:0]), acc_q[30:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[31:1]};
    end
    prod    = neg_q ? -step : step;
    div_sel = op_q[1] ? step[63:32] : step[31:0];
    if (op_q[2]) begin
      fin = neg_q ? -div_sel : div_sel;
    end else if (op_q[1:0] == 2'b00) begin
      fin = prod[31:0];
    end else begin
      fin = prod[63:32];
    end
  end

  // ---------------- FSM next state ----------------
  // NOTE: every next-state signal gets its hold value first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    data_d  = data_q;

    // kill wins over accept, iteration and the response handshake alike.
    if (bus.kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_d  = bus.req_op;
            rd_d  = bus.req_rd;
            neg_d = req_neg;
            cnt_d = 6'd0;
            if (bus.req_op[2]) begin
              if (div_by_zero) begin
                data_d  = bus.req_op[1] ? bus.req_rs1 : 32'hFFFF_FFFF;
                state_d = S_DONE;
              end else if (div_ovf) begin
                data_d  = bus.req_op[1] ? 32'd0 : 32'h8000_0000;
                state_d = S_DONE;
              end else begin
                acc_d   = {32'd0, mag_a};
                opb_d   = mag_b;
                state_d = S_ITER;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              data_d  = fast_res;
              state_d = S_DONE;
`else
              acc_d   = {32'd0, mag_b};
              opb_d   = mag_a;
              state_d = S_ITER;
`endif
            end
          end
        end
        S_ITER: begin
          acc_d = step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            data_d  = fin;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      opb_q   <= 32'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      neg_q   <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.resp_data  = data_q;
  assign bus.resp_rd    = rd_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;   // clock edges after the accept edge until resp_valid
  localparam int BYP_LAT = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_rd    = rd;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_data"}, bus.resp_data, exp);
    check({tag, "_rd"}, {27'd0, bus.resp_rd}, {27'd0, rd});
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_rs1    = 32'd0;
    bus.req_rs2    = 32'd0;
    bus.req_rd     = 5'd0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_data",  bus.resp_data, 32'd0);
    check("rst_rd",    {27'd0, bus.resp_rd}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // Multiply
    run_op("mul",     3'b000, 32'd3,          32'hFFFF_FFFB, 5'd1,  32'hFFFF_FFF1, MUL_LAT);
    run_op("mulh_mm", 3'b001, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, MUL_LAT);
    run_op("mulh_n",  3'b001, 32'hFFFF_FFFF,  32'd5,         5'd3,  32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhsu",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhu_s", 3'b011, 32'h0001_0000,  32'h0001_0000, 5'd6,  32'h0000_0001, MUL_LAT);

    // Divide
    run_op("div_n7",  3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_n7",  3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, DIV_LAT);
    run_op("div_dn",  3'b100, 32'd100,        32'hFFFF_FFF9, 5'd9,  32'hFFFF_FFF2, DIV_LAT);
    run_op("rem_dn",  3'b110, 32'd100,        32'hFFFF_FFF9, 5'd10, 32'h0000_0002, DIV_LAT);
    run_op("divu",    3'b101, 32'hFFFF_FFFF,  32'd10,        5'd11, 32'h1999_9999, DIV_LAT);
    run_op("remu",    3'b111, 32'hFFFF_FFFF,  32'd10,        5'd12, 32'h0000_0005, DIV_LAT);

    // Bypass cases
    run_op("divu_z",  3'b101, 32'd100,        32'd0,         5'd13, 32'hFFFF_FFFF, BYP_LAT);
    run_op("remu_z",  3'b111, 32'd100,        32'd0,         5'd14, 32'h0000_0064, BYP_LAT);
    run_op("div_z",   3'b100, 32'd5,          32'd0,         5'd15, 32'hFFFF_FFFF, BYP_LAT);
    run_op("rem_z",   3'b110, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9, BYP_LAT);
    run_op("div_ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000, BYP_LAT);
    run_op("rem_ovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h0000_0000, BYP_LAT);

    // Backpressure: DIVU 1000/7, consumer stalls 5 cycles while a new request waits
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b101;
    bus.req_rs1   = 32'd1000;
    bus.req_rs2   = 32'd7;
    bus.req_rd    = 5'd21;
    tick();
    bus.req_op    = 3'b011;   // pending request that must wait for IDLE
    seen = 0;
    while (!bus.resp_valid && seen < 100) begin
      tick();
      seen++;
    end
    check("bp_lat", 32'(seen), 32'(DIV_LAT));
    for (int k = 0; k < 5; k++) begin
      check("bp_data",  bus.resp_data, 32'h0000_008E);
      check("bp_rd",    {27'd0, bus.resp_rd}, 32'd21);
      check("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("bp_ready", {31'd0, bus.req_ready}, 32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    check("bp_hs_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    check("bp_post_busy",  {31'd0, bus.busy}, 32'd0);
    check("bp_post_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("bp_post_ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp_hold_data",  bus.resp_data, 32'h0000_008E);

    // kill 10 cycles into a DIV
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b100;
    bus.req_rs1   = 32'd1000;
    bus.req_rs2   = 32'd3;
    bus.req_rd    = 5'd9;
    tick();
    bus.req_valid = 1'b0;
    repeat (9) tick();
    check("kill_pre_busy", {31'd0, bus.busy}, 32'd1);
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("kill_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("kill_busy",  {31'd0, bus.busy}, 32'd0);
    check("kill_ready", {31'd0, bus.req_ready}, 32'd1);
    check("kill_data",  bus.resp_data, 32'h0000_008E);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.resp_valid) seen++;
      tick();
    end
    check("kill_no_resp", 32'(seen), 32'd0);

    // kill overrides a simultaneous accept
    bus.req_valid = 1'b1;
    bus.kill      = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    check("kill_acc_busy", {31'd0, bus.busy}, 32'd0);

    // rst mid-ITER
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b110;
    bus.req_rs1   = 32'd77;
    bus.req_rs2   = 32'd5;
    bus.req_rd    = 5'd30;
    tick();
    bus.req_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("arst_busy",  {31'd0, bus.busy}, 32'd0);
    check("arst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("arst_data",  bus.resp_data, 32'd0);
    check("arst_rd",    {27'd0, bus.resp_rd}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_ready", {31'd0, bus.req_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.resp_valid) seen++;
      tick();
    end
    check("arst_no_resp", 32'(seen), 32'd0);

    // Recovery after reset
    run_op("divu_rec", 3'b101, 32'd1000, 32'd7, 5'd31, 32'h0000_008E, DIV_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
